// File: rtl/axi4_master_write_response.sv
// axi4_master_write_response
// Master-side B-channel endpoint. Every write burst the master issues goes
// into an outstanding-transaction table when its AW handshake happens. The
// entry is marked data-complete when its last W beat has been accepted. A B
// response whose bid matches a data-complete entry retires that entry and
// produces a one-cycle completion pulse toward the master core.
//
// Handshake semantics: a transfer on any channel happens on a rising clk
// edge where both valid and ready are high. valid may not depend on ready.
// Only the cycle of that handshake has an effect. The AW and W channels are
// only observed here. On the B channel this block drives bready.
module axi4_master_write_response #(
    parameter int ID_WIDTH        = 4,
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                awvalid,
    input  logic                awready,
    input  logic [ID_WIDTH-1:0] awid,
    input  logic                wvalid,
    input  logic                wready,
    input  logic                wlast,
    input  logic                bvalid,
    input  logic [ID_WIDTH-1:0] bid,
    input  logic [1:0]          bresp,
    output logic                bready,
    output logic                aw_stall,
    output logic                cpl_valid,
    output logic [ID_WIDTH-1:0] cpl_id,
    output logic [1:0]          cpl_resp,
    output logic                cpl_err,
    output logic                unexp_err,
    output logic [CNT_W-1:0]    outstanding
);

    localparam int IDX_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MAX_OUTSTANDING - 1);

    // Outstanding-transaction table
    logic [MAX_OUTSTANDING-1:0] ent_valid;
    logic [MAX_OUTSTANDING-1:0] ent_done;
    logic [ID_WIDTH-1:0]        ent_id [MAX_OUTSTANDING];

    // W-order FIFO. It holds the table indices of bursts whose data is still pending.
    logic [IDX_W-1:0] fifo_mem [MAX_OUTSTANDING];
    logic [IDX_W-1:0] fifo_rd;
    logic [IDX_W-1:0] fifo_wr;
    logic [CNT_W-1:0] fifo_cnt;

    // This counter holds last beats that were seen before their AW handshake.
    logic [CNT_W-1:0] early_cnt;

    // Handshake events
    logic aw_fire;
    logic w_last_fire;
    logic b_fire;

    assign aw_fire     = awvalid & awready;
    assign w_last_fire = wvalid & wready & wlast;
    assign b_fire      = bvalid & bready;

    // Search results
    logic             free_found;
    logic [IDX_W-1:0] free_idx;
    logic             match_found;
    logic [IDX_W-1:0] match_idx;
    logic             id_hit;

    // Decoded per-cycle actions
    logic alloc;
    logic retire;
    logic unexp;
    logic fifo_empty;
    logic wl_to_fifo;
    logic alloc_early;
    logic wl_to_new;
    logic wl_early;
    logic push;

    // Next-state values
    logic [MAX_OUTSTANDING-1:0] valid_n;
    logic [MAX_OUTSTANDING-1:0] done_n;
    logic [CNT_W-1:0]           early_n;
    logic [CNT_W-1:0]           cnt_n;
    logic                       bready_n;

    function automatic logic [IDX_W-1:0] ptr_inc(input logic [IDX_W-1:0] p);
        return (p == IDX_LAST) ? '0 : p + IDX_W'(1);
    endfunction

    // This logic stalls AW issue when the table is full or awid is already in flight.
    // It uses the registered table, so an entry that retires this cycle still blocks its ID.
    always_comb begin
        id_hit = 1'b0;
        for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            if (ent_valid[i] && (ent_id[i] == awid)) begin
                id_hit = 1'b1;
            end
        end
        aw_stall = (&ent_valid) | id_hit;
    end

    // This logic finds the lowest free slot, and the data-complete entry that matches bid.
    always_comb begin
        free_found  = 1'b0;
        free_idx    = '0;
        match_found = 1'b0;
        match_idx   = '0;
        for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            if (!ent_valid[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
            if (ent_valid[i] && ent_done[i] && (ent_id[i] == bid) && !match_found) begin
                match_found = 1'b1;
                match_idx   = IDX_W'(i);
            end
        end
    end

    // This logic decodes the events of this cycle into table, FIFO and counter updates.
    always_comb begin
        alloc       = aw_fire & free_found;
        retire      = b_fire & match_found;
        unexp       = b_fire & ~match_found;
        fifo_empty  = (fifo_cnt == '0);
        // A last beat belongs to the oldest burst that still waits for data.
        wl_to_fifo  = w_last_fire & ~fifo_empty;
        // A burst whose data already went by is complete the moment it is allocated.
        alloc_early = alloc & (early_cnt != '0);
        wl_to_new   = w_last_fire & fifo_empty & alloc & (early_cnt == '0);
        wl_early    = w_last_fire & fifo_empty & ~wl_to_new;
        push        = alloc & ~alloc_early & ~wl_to_new;

        valid_n = ent_valid;
        done_n  = ent_done;
        if (wl_to_fifo) begin
            done_n[fifo_mem[fifo_rd]] = 1'b1;
        end
        if (alloc) begin
            valid_n[free_idx] = 1'b1;
            done_n[free_idx]  = alloc_early | wl_to_new;
        end
        if (retire) begin
            valid_n[match_idx] = 1'b0;
            done_n[match_idx]  = 1'b0;
        end

        early_n = early_cnt;
        if (alloc_early && !wl_early) begin
            early_n = early_cnt - CNT_W'(1);
        end else if (!alloc_early && wl_early && (early_cnt != CNT_MAX)) begin
            early_n = early_cnt + CNT_W'(1);
        end

        cnt_n = '0;
        for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            cnt_n = cnt_n + CNT_W'(valid_n[i]);
        end
        bready_n = |(valid_n & done_n);
    end

    // This block holds the table status, the FIFO pointers, the counters and the registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            ent_valid   <= '0;
            ent_done    <= '0;
            fifo_rd     <= '0;
            fifo_wr     <= '0;
            fifo_cnt    <= '0;
            early_cnt   <= '0;
            bready      <= 1'b0;
            cpl_valid   <= 1'b0;
            cpl_id      <= '0;
            cpl_resp    <= 2'b00;
            cpl_err     <= 1'b0;
            unexp_err   <= 1'b0;
            outstanding <= '0;
        end else begin
            ent_valid   <= valid_n;
            ent_done    <= done_n;
            early_cnt   <= early_n;
            bready      <= bready_n;
            outstanding <= cnt_n;
            if (push) begin
                fifo_wr <= ptr_inc(fifo_wr);
            end
            if (wl_to_fifo) begin
                fifo_rd <= ptr_inc(fifo_rd);
            end
            case ({push, wl_to_fifo})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
            cpl_valid <= retire;
            unexp_err <= unexp;
            if (retire) begin
                cpl_id   <= bid;
                cpl_resp <= bresp;
                cpl_err  <= bresp[1];
            end
        end
    end

    // This block stores the entry IDs and the FIFO contents. Each value is only read after the matching status bit is set.
    always_ff @(posedge clk) begin
        if (alloc) begin
            ent_id[free_idx] <= awid;
        end
        if (push) begin
            fifo_mem[fifo_wr] <= free_idx;
        end
    end

endmodule

// File: tb/tb_axi4_master_write_response.sv
// Bench for axi4_master_write_response: directed vector table, reset and
// W-before-AW sequences, then random traffic against a transaction-level model.
module tb_axi4_master_write_response;

  localparam int IDW  = 4;
  localparam int MAXO = 4;
  localparam int CW   = $clog2(MAXO + 1);

  logic           clk = 1'b0;
  logic           rst;
  logic           awvalid, awready;
  logic [IDW-1:0] awid;
  logic           wvalid, wready, wlast;
  logic           bvalid;
  logic [IDW-1:0] bid;
  logic [1:0]     bresp;
  logic           bready, aw_stall, cpl_valid, cpl_err, unexp_err;
  logic [IDW-1:0] cpl_id;
  logic [1:0]     cpl_resp;
  logic [CW-1:0]  outstanding;

  axi4_master_write_response #(
    .ID_WIDTH(IDW), .MAX_OUTSTANDING(MAXO), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .awvalid(awvalid), .awready(awready), .awid(awid),
    .wvalid(wvalid), .wready(wready), .wlast(wlast),
    .bvalid(bvalid), .bid(bid), .bresp(bresp),
    .bready(bready), .aw_stall(aw_stall),
    .cpl_valid(cpl_valid), .cpl_id(cpl_id), .cpl_resp(cpl_resp), .cpl_err(cpl_err),
    .unexp_err(unexp_err), .outstanding(outstanding)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic           awv;
    logic [IDW-1:0] awid;
    logic           wl;
    logic           bv;
    logic [IDW-1:0] bid;
    logic [1:0]     br;
    logic           e_stall;
    logic           e_bready;
    logic [CW-1:0]  e_out;
    logic           e_cpl;
    logic [IDW-1:0] e_cid;
    logic [1:0]     e_cresp;
    logic           e_unexp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input int av, input int aid, input int wl, input int bv, input int b_id,
                              input int br, input int es, input int eb, input int eo, input int ec,
                              input int eci, input int ecr, input int eu);
    vec_t r;
    r.awv = av[0];      r.awid = aid[IDW-1:0]; r.wl = wl[0];
    r.bv = bv[0];       r.bid = b_id[IDW-1:0]; r.br = br[1:0];
    r.e_stall = es[0];  r.e_bready = eb[0];    r.e_out = eo[CW-1:0];
    r.e_cpl = ec[0];    r.e_cid = eci[IDW-1:0]; r.e_cresp = ecr[1:0]; r.e_unexp = eu[0];
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic av, input logic ar, input logic [IDW-1:0] aid,
                       input logic wv, input logic wr, input logic wl, input logic bv,
                       input logic [IDW-1:0] b_id, input logic [1:0] br);
    rst = r; awvalid = av; awready = ar; awid = aid;
    wvalid = wv; wready = wr; wlast = wl;
    bvalid = bv; bid = b_id; bresp = br;
  endtask

  // One cycle: apply inputs, check aw_stall before the edge, then check registered outputs after it.
  task automatic apply_vec(input string tag, input logic r, input vec_t x);
    drive(r, x.awv, 1'b1, x.awid, x.wl, 1'b1, x.wl, x.bv, x.bid, x.br);
    #1;
    chk({tag, " aw_stall"}, aw_stall, x.e_stall);
    @(posedge clk);
    #1;
    chk({tag, " bready"}, bready, x.e_bready);
    chk({tag, " outstanding"}, outstanding, x.e_out);
    chk({tag, " cpl_valid"}, cpl_valid, x.e_cpl);
    chk({tag, " unexp_err"}, unexp_err, x.e_unexp);
    if (x.e_cpl) begin
      chk({tag, " cpl_id"}, cpl_id, x.e_cid);
      chk({tag, " cpl_resp"}, cpl_resp, x.e_cresp);
      chk({tag, " cpl_err"}, cpl_err, x.e_cresp[1]);
    end
  endtask

  // Transaction-level model state
  logic [IDW-1:0] m_id[$];
  bit             m_done[$];
  logic [IDW-1:0] m_wq[$];
  int             m_early;
  bit             m_bready;

  logic           r_rst, r_av, r_ar, r_wv, r_wr, r_wl, r_bv;
  logic [IDW-1:0] r_aid, r_bid, w_id;
  logic [1:0]     r_br;
  bit             e_stall, e_cpl, e_unexp, found;
  logic [IDW-1:0] e_cid;
  logic [1:0]     e_cresp;
  int             sel;

  initial begin
    drive(1'b1, 0, 0, '0, 0, 0, 0, 0, '0, 2'b00);
    repeat (2) @(posedge clk);
    #1;
    chk("reset bready", bready, 0);
    chk("reset cpl_valid", cpl_valid, 0);
    chk("reset cpl_id", cpl_id, 0);
    chk("reset cpl_resp", cpl_resp, 0);
    chk("reset cpl_err", cpl_err, 0);
    chk("reset unexp_err", unexp_err, 0);
    chk("reset outstanding", outstanding, 0);
    chk("reset aw_stall", aw_stall, 0);

    // awv awid wl | bv bid br | stall bready out | cpl cid cresp | unexp
    // single write, id 3
    vecs.push_back(mk(1, 3, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 3, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 3, 0, 0, 0, 0, 1, 3, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // fill the table with ids 0..3, return 2, then drain
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0));
    vecs.push_back(mk(1, 2, 1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0));
    vecs.push_back(mk(1, 3, 1, 0, 0, 0, 0, 1, 4, 0, 0, 0, 0));
    vecs.push_back(mk(0, 5, 0, 0, 0, 0, 1, 1, 4, 0, 0, 0, 0));
    vecs.push_back(mk(0, 5, 0, 1, 2, 0, 1, 1, 3, 1, 2, 0, 0));
    vecs.push_back(mk(0, 5, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0));
    vecs.push_back(mk(0, 5, 0, 1, 0, 0, 0, 1, 2, 1, 0, 0, 0));
    vecs.push_back(mk(0, 5, 0, 1, 1, 0, 0, 1, 1, 1, 1, 0, 0));
    vecs.push_back(mk(0, 5, 0, 1, 3, 1, 0, 0, 0, 1, 3, 1, 0));
    // out-of-order completion; bvalid while bready is low is ignored
    vecs.push_back(mk(1, 5, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 6, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0));
    vecs.push_back(mk(1, 7, 0, 1, 5, 0, 0, 0, 3, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 7, 2, 0, 1, 2, 1, 7, 2, 0));
    vecs.push_back(mk(0, 0, 0, 1, 5, 0, 0, 1, 1, 1, 5, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 6, 1, 0, 0, 0, 1, 6, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // duplicate-ID throttle for id 9
    vecs.push_back(mk(1, 9, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 9, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 9, 0, 1, 9, 0, 1, 0, 0, 1, 9, 0, 0));
    vecs.push_back(mk(0, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // unexpected responses: unknown id, then an id whose W is not done
    vecs.push_back(mk(1, 4, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 10, 0, 0, 1, 1, 0, 0, 0, 1));
    vecs.push_back(mk(1, 8, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 8, 0, 0, 1, 2, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 1, 4, 3, 0, 0, 1, 1, 4, 3, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 8, 0, 0, 0, 0, 1, 8, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      apply_vec($sformatf("vec%0d", i), 1'b0, vecs[i]);
    end

    // reset mid-flight: three complete writes plus one stray wlast, then reset with a response offered
    apply_vec("rst_a", 1'b0, mk(1, 1, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
    apply_vec("rst_b", 1'b0, mk(1, 2, 1, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0));
    apply_vec("rst_c", 1'b0, mk(1, 3, 1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0));
    apply_vec("rst_d", 1'b0, mk(0, 0, 1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0));
    apply_vec("rst_e", 1'b1, mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    // the stray wlast is gone after reset, so this burst still waits for data
    apply_vec("rst_f", 1'b0, mk(1, 2, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    apply_vec("rst_g", 1'b0, mk(0, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
    apply_vec("rst_h", 1'b0, mk(0, 0, 0, 1, 2, 0, 0, 0, 0, 1, 2, 0, 0));
    // W before AW
    apply_vec("early_a", 1'b0, mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    apply_vec("early_b", 1'b0, mk(1, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
    apply_vec("early_c", 1'b0, mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 1, 0, 0));

    // random traffic against the transaction-level model
    drive(1'b1, 0, 0, '0, 0, 0, 0, 0, '0, 2'b00);
    @(posedge clk);
    #1;
    m_id.delete(); m_done.delete(); m_wq.delete(); m_early = 0; m_bready = 0;
    for (int n = 0; n < 3000; n++) begin
      r_rst = ($urandom_range(0, 199) == 0);
      r_aid = IDW'($urandom_range(0, 7));
      e_stall = (m_id.size() == MAXO);
      for (int k = 0; k < m_id.size(); k++) if (m_id[k] == r_aid) e_stall = 1;
      r_av = !e_stall && ($urandom_range(0, 2) == 0);
      r_ar = ($urandom_range(0, 3) != 0);
      r_wv = $urandom_range(0, 1);
      r_wr = $urandom_range(0, 1);
      r_wl = $urandom_range(0, 1);
      r_bv = $urandom_range(0, 1);
      if (m_id.size() > 0 && $urandom_range(0, 3) != 0) begin
        sel = $urandom_range(0, m_id.size() - 1);
        r_bid = m_id[sel];
      end else begin
        r_bid = IDW'($urandom_range(0, 15));
      end
      r_br = 2'($urandom_range(0, 3));
      drive(r_rst, r_av, r_ar, r_aid, r_wv, r_wr, r_wl, r_bv, r_bid, r_br);
      #1;
      chk("rnd aw_stall", aw_stall, e_stall);

      e_cpl = 0; e_unexp = 0; e_cid = '0; e_cresp = 2'b00;
      if (r_rst) begin
        m_id.delete(); m_done.delete(); m_wq.delete(); m_early = 0;
      end else begin
        // responses are matched against the state at the start of the cycle
        if (r_bv && m_bready) begin
          found = 0;
          for (int k = 0; k < m_id.size(); k++) begin
            if (!found && m_id[k] == r_bid && m_done[k]) begin
              found = 1; sel = k;
            end
          end
          if (found) begin
            e_cpl = 1; e_cid = r_bid; e_cresp = r_br;
            m_id.delete(sel); m_done.delete(sel);
          end else begin
            e_unexp = 1;
          end
        end
        // new burst joins the table; its data may already have gone by
        if (r_av && r_ar) begin
          m_id.push_back(r_aid);
          if (m_early > 0) begin
            m_done.push_back(1); m_early--;
          end else begin
            m_done.push_back(0); m_wq.push_back(r_aid);
          end
        end
        // last beats complete bursts in AW order
        if (r_wv && r_wr && r_wl) begin
          if (m_wq.size() > 0) begin
            w_id = m_wq.pop_front();
            for (int k = 0; k < m_id.size(); k++) if (m_id[k] == w_id) m_done[k] = 1;
          end else if (m_early < MAXO) begin
            m_early++;
          end
        end
      end
      m_bready = 0;
      for (int k = 0; k < m_done.size(); k++) if (m_done[k]) m_bready = 1;

      @(posedge clk);
      #1;
      chk("rnd bready", bready, m_bready);
      chk("rnd outstanding", outstanding, m_id.size());
      chk("rnd cpl_valid", cpl_valid, e_cpl);
      chk("rnd unexp_err", unexp_err, e_unexp);
      if (e_cpl) begin
        chk("rnd cpl_id", cpl_id, e_cid);
        chk("rnd cpl_resp", cpl_resp, e_cresp);
        chk("rnd cpl_err", cpl_err, e_cresp[1]);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
